// File: rtl/tff_mod_counter_if.sv
// rtl/tff_mod_counter_if.sv - control/status bundle for the counter/toggle primitive
interface tff_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             mode;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] t;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             wrap;

  modport master (
    output mode, en, up, t, load, load_val,
    input  q, wrap
  );

  modport slave (
    input  mode, en, up, t, load, load_val,
    output q, wrap
  );
endinterface

// File: rtl/tff_mod_counter.sv
// rtl/tff_mod_counter.sv - WIDTH-bit T-flip-flop bank / modulo up-down counter with load and wrap flag
// Optional: define TFF_CNT_SAT_EN to make counter mode saturate at 0 and MODULUS-1 instead of wrapping.
module tff_mod_counter #(
  parameter int          WIDTH   = 4,
  parameter longint      MODULUS = 10
) (
  input logic              clk,
  input logic              rst,
  tff_mod_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_r, q_nxt;
  logic             wrap_r, wrap_nxt;

  always_comb begin
    q_nxt    = q_r;
    wrap_nxt = 1'b0;
    if (bus.load) begin
      q_nxt = bus.load_val;
    end else if (bus.en) begin
      if (!bus.mode) begin
        q_nxt = q_r ^ bus.t;
      end else if (bus.up) begin
        if (q_r >= MAX_Q) begin
`ifdef TFF_CNT_SAT_EN
          q_nxt    = MAX_Q;
`else
          q_nxt    = '0;
`endif
          wrap_nxt = 1'b1;
        end else begin
          q_nxt = q_r + WIDTH'(1);
        end
      end else begin
        if (q_r == '0) begin
`ifdef TFF_CNT_SAT_EN
          q_nxt    = '0;
`else
          q_nxt    = MAX_Q;
`endif
          wrap_nxt = 1'b1;
        end else if (q_r > MAX_Q) begin
          // out-of-range values from load or toggle mode snap back into range
          q_nxt = MAX_Q;
        end else begin
          q_nxt = q_r - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  assign bus.q    = q_r;
  assign bus.wrap = wrap_r;
endmodule

// File: tb/tb_tff_mod_counter.sv
// tb/tb_tff_mod_counter.sv - directed bench with cycle-by-cycle reference model for tff_mod_counter
module tb_tff_mod_counter;
  localparam int W   = 4;
  localparam int MOD = 10;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   mq       = 0;
  bit   mw       = 1'b0;
  bit   started  = 1'b0;

  always #5 clk = ~clk;

  tff_mod_counter_if #(.WIDTH(W)) bus ();

  tff_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: value as an integer in 0..2**W-1, rules applied with plain arithmetic
  always @(posedge clk) begin
    if (rst) begin
      mq = 0; mw = 1'b0;
    end else if (bus.load) begin
      mq = int'(bus.load_val); mw = 1'b0;
    end else if (bus.en && !bus.mode) begin
      mq = mq ^ int'(bus.t); mw = 1'b0;
    end else if (bus.en && bus.up) begin
      if (mq >= MOD - 1) begin
`ifdef TFF_CNT_SAT_EN
        mq = MOD - 1;
`else
        mq = 0;
`endif
        mw = 1'b1;
      end else begin
        mq = (mq + 1) % (1 << W); mw = 1'b0;
      end
    end else if (bus.en) begin
      if (mq == 0) begin
`ifdef TFF_CNT_SAT_EN
        mq = 0;
`else
        mq = MOD - 1;
`endif
        mw = 1'b1;
      end else if (mq > MOD - 1) begin
        mq = MOD - 1; mw = 1'b0;
      end else begin
        mq = mq - 1; mw = 1'b0;
      end
    end else begin
      mw = 1'b0;
    end
    started = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    if (started) begin
      checks++;
      if (bus.q !== W'(mq) || bus.wrap !== mw) begin
        failures++;
        $display("FAIL model t=%0t q=%0d wrap=%b expected q=%0d wrap=%b",
                 $time, bus.q, bus.wrap, mq, mw);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int eq, input bit ew);
    checks++;
    if (bus.q !== W'(eq) || bus.wrap !== ew) begin
      failures++;
      $display("FAIL %s q=%0d wrap=%b expected q=%0d wrap=%b", name, bus.q, bus.wrap, eq, ew);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.load = 1'b1; bus.load_val = 4'd7; bus.en = 1'b1;
    bus.mode = 1'b0; bus.up = 1'b1; bus.t = 4'd0;
    step(); chk("reset1", 0, 0);
    step(); chk("reset2", 0, 0);
    rst = 1'b0; bus.load = 1'b0; bus.en = 1'b0;
    step(); chk("reset_release", 0, 0);

    bus.mode = 1'b0; bus.en = 1'b1; bus.t = 4'b0101;
    step(); chk("tog1", 5, 0);
    step(); chk("tog2", 0, 0);
    step(); chk("tog3", 5, 0);
    bus.t = 4'b0000;
    step(); chk("tog_hold", 5, 0);

    bus.load = 1'b1; bus.load_val = 4'd0;
    step(); chk("load0", 0, 0);
    bus.load = 1'b0; bus.mode = 1'b1; bus.up = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step(); chk("count_up", i, 0);
    end
    step();
`ifdef TFF_CNT_SAT_EN
    chk("up_limit", 9, 1);
`else
    chk("up_wrap", 0, 1);
`endif
    bus.load = 1'b1; bus.load_val = 4'd0;
    step();
    bus.load = 1'b0; bus.up = 1'b0;
    step();
`ifdef TFF_CNT_SAT_EN
    chk("down_limit", 0, 1);
`else
    chk("down_wrap", 9, 1);
`endif
    bus.en = 1'b0;
    step(); chk("idle_clears_wrap", mq, 0);

    bus.load = 1'b1; bus.load_val = 4'd7; bus.en = 1'b1;
    step(); chk("load_over_en", 7, 0);
    bus.load = 1'b0; bus.up = 1'b0;
    step(); chk("down_mid", 6, 0);
    bus.load = 1'b1; bus.load_val = 4'd15;
    step(); chk("load15", 15, 0);
    bus.load = 1'b0; bus.up = 1'b1;
    step();
`ifdef TFF_CNT_SAT_EN
    chk("oor_up", 9, 1);
`else
    chk("oor_up", 0, 1);
`endif
    bus.load = 1'b1; bus.load_val = 4'd15;
    step();
    bus.load = 1'b0; bus.up = 1'b0;
    step(); chk("oor_down", 9, 0);

    bus.load = 1'b1; bus.load_val = 4'd4;
    step();
    bus.load = 1'b0; bus.up = 1'b1;
    step(); chk("count_to5", 5, 0);
    rst = 1'b1; bus.load = 1'b1; bus.load_val = 4'd7;
    step(); chk("mid_reset", 0, 0);
    rst = 1'b0; bus.load = 1'b0;
    step(); chk("resume", 1, 0);
    step(); chk("resume2", 2, 0);

    bus.mode = 1'b0; bus.t = 4'b1010;
    step(); chk("mode_switch_tog", 8, 0);
    bus.mode = 1'b1; bus.up = 1'b0;
    step(); chk("mode_switch_cnt", 7, 0);

`ifdef TFF_CNT_SAT_EN
    bus.load = 1'b1; bus.load_val = 4'd9;
    step();
    bus.load = 1'b0; bus.up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("sat_up", 9, 1);
    end
    bus.load = 1'b1; bus.load_val = 4'd0;
    step();
    bus.load = 1'b0; bus.up = 1'b0;
    step(); chk("sat_down", 0, 1);
    bus.en = 1'b0;
    step(); chk("sat_idle", 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
